// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop synchroniser, mid-bit sampling FSM and a one-entry
// valid/ready holding register. Define UART_RX_PARITY_EN to add an even-parity bit.
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | half-bit wait, then confirm start bit
// DATA   | sampling data bits 0..7 at mid-bit
// PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling stop bit, completing or rejecting the byte
// BREAK  | line held low after a framing error; wait for it to return high

module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] BIT_LOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LOAD = 16'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        rx_s_q, rx_s_d;
  logic [15:0] timer_q, timer_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        byte_done;
  logic        expired;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad_q, parity_bad_d;
`endif

  assign expired = (timer_q == 16'd0);

  always_comb begin
    sync1_d     = io_rx;
    rx_s_d      = sync1_q;
    state_d     = state_q;
    timer_d     = expired ? timer_q : timer_q - 16'd1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          timer_d = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (expired) begin
          if (!rx_s_q) begin
            timer_d = BIT_LOAD;
            idx_d   = 3'd0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (expired) begin
          shift_d[idx_q] = rx_s_q;
          timer_d        = BIT_LOAD;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (expired) begin
          parity_bad_d = (^shift_q) ^ rx_s_q;
          timer_d      = BIT_LOAD;
          state_d      = STOP;
        end
      end
`endif
      STOP: begin
        if (expired) begin
          if (rx_s_q) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) frame_err_d = 1'b1;
            else              byte_done   = 1'b1;
`else
            byte_done = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Holding register: a simultaneous transfer frees the slot for the new byte.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (byte_done) begin
      if (!valid_q || rx_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= IDLE;
      timer_q     <= 16'd0;
      idx_q       <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      rx_s_q      <= rx_s_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receive front-end that sits between the `io_rx` input pad and the CPU core.
- Synchronises the asynchronous serial line and detects start bits.
- Samples 8N1 frames at mid-bit and presents each received byte through a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns as single-cycle pulses; the consumer (program loader / CPU I/O logic) uses these for error handling.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434 (50 MHz / 115200): clock cycles per serial bit. Legal range is 4 to 65535; other values are illegal.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `io_rx`  input  1  asynchronous serial line; idles high.
- `rx_data`  output  8  received byte, LSB = first data bit.
- `rx_valid`  output  1  `rx_data` holds an unconsumed byte.
- `rx_ready`  input  1  consumer accepts the byte; a transfer occurs when `rx_valid && rx_ready`.
- `frame_err`  output  1  one-cycle pulse on a bad stop bit (or bad parity, see Configuration).
- `overrun`  output  1  one-cycle pulse when a completed byte is dropped.

## Operation
- Input path: a 2-flop synchroniser produces `rx_s`. The FSM uses only `rx_s`.
- Bit timer: a 16-bit down-counter; `H = CLKS_PER_BIT/2` (floor).
- FSM states: IDLE, START, DATA, [PARITY], STOP, BREAK.
  - IDLE: when `rx_s == 0`, load timer with `H-1` and go to START.
  - START: at timer expiry, sample `rx_s`.
    - `rx_s == 0`: load timer with `CLKS_PER_BIT-1`, clear the bit index, go to DATA.
    - `rx_s == 1`: treat as a glitch and return to IDLE with no output.
  - DATA: at each expiry, shift `rx_s` into bit[idx] (LSB first) and reload the timer. After bit 7, go to STOP (or PARITY when enabled).
  - STOP: at expiry, sample `rx_s`.
    - `rx_s == 1`: the byte is complete; go to IDLE.
    - `rx_s == 0`: pulse `frame_err`, discard the byte, go to BREAK.
  - BREAK: wait for `rx_s == 1`, then go to IDLE. This prevents a held-low line from retriggering.
- Byte completion with an empty holding register: load it and set `rx_valid`.
- Byte completion with a full holding register and `rx_ready == 1` in the same cycle: the old byte transfers, the new byte loads, and `rx_valid` stays 1.
- Byte completion with a full holding register and `rx_ready == 0`: the new byte is dropped, `overrun` pulses, and `rx_data` is unchanged.
- `rx_valid` falls the cycle after a transfer when no new byte loads. `rx_data` is stable while `rx_valid == 1`.
- Reset (any cycle, including mid-frame):
  - FSM goes to IDLE, timer and bit index are cleared.
  - Synchroniser flops are set to 1.
  - `rx_valid = 0`, `rx_data = 8'h00`, `frame_err = 0`, `overrun = 0`.
  - A partially received frame is discarded. If the line is still low after reset, that is treated as a new start bit.

## Timing
- Sample instants: take edge E0 as the first edge where `rx_s` is seen low in IDLE.
  - Start bit is verified at E0 + H.
  - Data bit k is sampled at E0 + H + (k+1)·`CLKS_PER_BIT`.
  - Stop bit is sampled at E0 + H + 9·`CLKS_PER_BIT` (10·`CLKS_PER_BIT` with parity).
- `rx_valid` (or `frame_err`) is registered and asserts the cycle after the stop sample.
- Latency from the line's falling edge to `rx_valid` is 2 (synchroniser) + H + 9·`CLKS_PER_BIT` + 1 cycles, with ±1 cycle for synchroniser phase.
- Back-to-back frames: IDLE is re-entered on the stop sample, so a start edge at E0 + H + 9·`CLKS_PER_BIT` + 1 is detected. No idle gap is required.
- `frame_err` and `overrun` are high for exactly one cycle and are never asserted in the same cycle.
- `rx_ready` has no combinational path to any output.

## Configuration
- Macro `UART_RX_PARITY_EN`:
  - Defined: an even-parity bit follows bit 7 and is sampled in the PARITY state one `CLKS_PER_BIT` after bit 7. A parity mismatch discards the byte, pulses `frame_err` at the stop sample, and returns to IDLE (not BREAK) when the stop bit is 1.
  - Undefined: 8N1 frames only; the PARITY state and its logic are not compiled.

## Test plan
All scenarios use `CLKS_PER_BIT = 8`.
- Reset, then send frame 0xA5 with `rx_ready = 0`: `rx_valid` rises at the computed latency, `rx_data == 8'hA5`. Raise `rx_ready` for 1 cycle: `rx_valid` drops the next cycle.
- Pull `io_rx` low for 3 cycles, then high: no `rx_valid`, no `frame_err`, FSM back in IDLE. A following 0x3C frame is received correctly.
- Send 0x55 with stop bit = 0 and the line held low 40 cycles: `frame_err` pulses once, no `rx_valid`. After the line goes high, 0x0F is received correctly.
- Send 0x11 then 0x22 back-to-back with `rx_ready = 0`: `rx_data` stays 0x11, `overrun` pulses once at the second stop sample.
  - Repeat with `rx_ready = 1` in the second byte's load cycle: 0x11 transfers, 0x22 appears, `rx_valid` stays high.
- Assert `reset` for 1 cycle during data bit 4 of 0xFF: no `rx_valid`. The remaining line activity causes no spurious `rx_valid` unless it forms a valid frame. The next clean frame, 0x81, is received correctly.
- With `UART_RX_PARITY_EN` defined: 0x03 with parity 0 is received; 0x03 with parity 1 produces a `frame_err` pulse and no `rx_valid`.
